// File: rtl/dbus_to_sramx_pipe.sv
// CPU data-bus to fixed-latency SRAMx adapter with misalignment blocking and saturating counters.
// Latency: dsreq is combinational in the request cycle; data_ok/derr follow LATENCY cycles later.
// Backpressure: none, addr_ok is tied high and one request is taken every cycle.
package dbus_sramx_pkg;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sramx_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } sramx_resp_t;

endpackage

module dbus_to_sramx_pipe
    import dbus_sramx_pkg::*;
#(
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned CHECK_ALIGN = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  dbus_req_t         dreq,
    output dbus_resp_t        dresp,
    output sramx_req_t        dsreq,
    input  sramx_resp_t       dsresp,
    output logic              derr,
    output logic [CNT_W-1:0]  req_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("dbus_to_sramx_pipe: LATENCY must be in 1..4");
    end

    typedef struct packed {
        logic v;
        logic mis;
    } tag_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             mis;
    logic             en;
    tag_t             tag_d [LATENCY];
    tag_t             tag_q [LATENCY];
    tag_t             tag_last;
    logic [CNT_W-1:0] req_cnt_d, req_cnt_q;
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

    // Sizes beyond a word are illegal encodings and are rejected like misaligned ones.
    always_comb begin
        mis = 1'b0;
        if (CHECK_ALIGN != 0) begin
            case (dreq.size)
                MSIZE1:  mis = 1'b0;
                MSIZE2:  mis = dreq.addr[0];
                MSIZE4:  mis = |dreq.addr[1:0];
                default: mis = 1'b1;
            endcase
        end
    end

    always_comb begin
        en          = dreq.valid & ~mis;
        dsreq.en    = en;
        dsreq.wen   = en ? dreq.strobe : 4'b0000;
        dsreq.addr  = dreq.addr;
        dsreq.wdata = dreq.data;
    end

    always_comb begin
        tag_d[0].v   = dreq.valid;
        tag_d[0].mis = dreq.valid & mis;
        for (int k = 1; k < LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        if (!resetn) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_d[k] = '0;
            end
        end
    end

    always_comb begin
        req_cnt_d = req_cnt_q;
        err_cnt_d = err_cnt_q;
        if (dreq.valid && req_cnt_q != CNT_MAX) begin
            req_cnt_d = req_cnt_q + CNT_ONE;
        end
        if (dreq.valid && mis && err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
        if (!resetn) begin
            req_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LATENCY; k++) begin
            tag_q[k] <= tag_d[k];
        end
        req_cnt_q <= req_cnt_d;
        err_cnt_q <= err_cnt_d;
    end

    // Completion is decided purely by the oldest tag; rdata is passed through unless blocked.
    always_comb begin
        tag_last      = tag_q[LATENCY-1];
        dresp.addr_ok = 1'b1;
        dresp.data_ok = tag_last.v;
        dresp.data    = tag_last.mis ? 32'h0000_0000 : dsresp.rdata;
        derr          = tag_last.v & tag_last.mis;
        req_cnt       = req_cnt_q;
        err_cnt       = err_cnt_q;
    end

endmodule
